// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : uart_pkg                                                     |
// | Purpose : Shared types and constants for the configurable UART         |
// |           transmitter: FSM state encoding, parity-mode codes and the   |
// |           smallest supported data length.                              |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity mode codes on i_parity; 2'b11 behaves like PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_DATA_BITS = 5;

endpackage
`default_nettype wire

// File: rtl/transmitter_cfg_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface: transmitter_cfg_if                                          |
// | Purpose  : Bundles the transmitter's tick, FIFO, frame-config and      |
// |            serial-line signals.                                        |
// | Ports    : i_stick, i_tx_en, i_fifo_empty, i_tx_data, i_data_bits,     |
// |            i_parity, i_stop2 (into the transmitter);                   |
// |            o_fifo_rd, o_tx_serial, o_busy, o_tx_done (out of it).      |
// | Modports : slave  - the transmitter                                    |
// |            master - whatever drives it (FIFO/top level/testbench)      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface transmitter_cfg_if #(
  parameter int SIZE_DATA = 8
);
  localparam int DB_W = $clog2(SIZE_DATA + 1);

  logic                 i_stick;
  logic                 i_tx_en;
  logic                 i_fifo_empty;
  logic [SIZE_DATA-1:0] i_tx_data;
  logic [DB_W-1:0]      i_data_bits;
  logic [1:0]           i_parity;
  logic                 i_stop2;
  logic                 o_fifo_rd;
  logic                 o_tx_serial;
  logic                 o_busy;
  logic                 o_tx_done;

  modport slave (
    input  i_stick, i_tx_en, i_fifo_empty, i_tx_data,
           i_data_bits, i_parity, i_stop2,
    output o_fifo_rd, o_tx_serial, o_busy, o_tx_done
  );

  modport master (
    output i_stick, i_tx_en, i_fifo_empty, i_tx_data,
           i_data_bits, i_parity, i_stop2,
    input  o_fifo_rd, o_tx_serial, o_busy, o_tx_done
  );

endinterface
`default_nettype wire

// File: rtl/transmitter_cfg_tx_bit_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tx_bit_timer                                                 |
// | Purpose : Counts oversample ticks and flags the tick that completes a  |
// |           bit period. The FSM restarts it on every state entry.        |
// | Ports   : i_clk, i_rst    - clock, synchronous active-high reset       |
// |           i_restart       - clear the count (state entry / idle)       |
// |           i_stick         - oversample tick                            |
// |           o_bit_end       - high during the tick that ends the bit     |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tx_bit_timer #(
  parameter int OVER_SAMPLE = 16
) (
  input  wire logic i_clk,
  input  wire logic i_rst,
  input  wire logic i_restart,
  input  wire logic i_stick,
  output logic      o_bit_end
);

  localparam int              CNT_W       = (OVER_SAMPLE > 1) ? $clog2(OVER_SAMPLE) : 1;
  localparam logic [CNT_W-1:0] c_last_tick = CNT_W'(OVER_SAMPLE - 1);

  logic [CNT_W-1:0] r_cnt;

  // The counter wraps by itself between consecutive bits of the same state,
  // so restart only matters when a new state begins.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) begin
      r_cnt <= '0;
    end else if (i_stick) begin
      r_cnt <= (r_cnt == c_last_tick) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_bit_end = i_stick && (r_cnt == c_last_tick);

endmodule
`default_nettype wire

// File: rtl/transmitter_cfg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : transmitter_cfg                                              |
// | Purpose : UART transmitter with runtime frame format: 5..SIZE_DATA     |
// |           data bits, none/even/odd parity, one or two stop bits.       |
// |           Pops one word per frame from the TX FIFO and serialises it   |
// |           LSB first, paced by the oversample tick.                     |
// | Ports   : i_clk, i_rst - clock, synchronous active-high reset          |
// |           bus (slave)  - tick, FIFO handshake, frame config, serial    |
// |                          line, busy and done status                    |
// | Build   : define UART_TX_PARITY_EN to build the parity bit; otherwise  |
// |           i_parity is ignored and frames never carry parity.           |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module transmitter_cfg
  import uart_pkg::*;
#(
  parameter int SIZE_DATA   = 8,
  parameter int OVER_SAMPLE = 16
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst,
  transmitter_cfg_if.slave  bus
);

  localparam int              DB_W       = $clog2(SIZE_DATA + 1);
  localparam logic [DB_W-1:0] c_min_bits = DB_W'(MIN_DATA_BITS);
  localparam logic [DB_W-1:0] c_max_bits = DB_W'(SIZE_DATA);

  tx_state_e r_state;
  tx_state_e w_next;

  // Shadow copy of the frame, taken when the word is popped.
  logic [SIZE_DATA-1:0] r_shift;
  logic [DB_W-1:0]      r_nbits;
  logic                 r_stop2;
  logic [DB_W-1:0]      r_bit_cnt;
  logic                 r_stop_cnt;

  logic r_fifo_rd;
  logic r_tx_serial;
  logic r_busy;
  logic r_tx_done;

  logic            w_bit_end;
  logic            w_start;
  logic            w_restart;
  logic            w_last_data;
  logic            w_par_next;
  logic            w_line;
  logic [DB_W-1:0] w_nbits;

  assign w_start     = (r_state == ST_IDLE) && bus.i_tx_en && !bus.i_fifo_empty;
  assign w_last_data = (r_bit_cnt == r_nbits - 1'b1);
  // Idle keeps the timer cleared so the start bit begins from zero ticks.
  assign w_restart   = (r_state != w_next) || (r_state == ST_IDLE);

  always_comb begin
    w_nbits = bus.i_data_bits;
    if (bus.i_data_bits < c_min_bits) begin
      w_nbits = c_min_bits;
    end else if (bus.i_data_bits > c_max_bits) begin
      w_nbits = c_max_bits;
    end
  end

  tx_bit_timer #(
    .OVER_SAMPLE (OVER_SAMPLE)
  ) u_bit_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (w_restart),
    .i_stick   (bus.i_stick),
    .o_bit_end (w_bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_bit;
  logic w_data_xor;

  // XOR only over the bits that will actually be sent.
  always_comb begin
    w_data_xor = 1'b0;
    for (int i = 0; i < SIZE_DATA; i++) begin
      if (i < int'(w_nbits)) begin
        w_data_xor = w_data_xor ^ bus.i_tx_data[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_start) begin
      r_par_en  <= (bus.i_parity == PAR_EVEN) || (bus.i_parity == PAR_ODD);
      r_par_bit <= w_data_xor ^ (bus.i_parity == PAR_ODD);
    end
  end

  assign w_par_next = r_par_en;
`else
  logic w_unused_parity;
  assign w_unused_parity = ^bus.i_parity;
  assign w_par_next      = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_START;
      end
      ST_START: begin
        if (w_bit_end) w_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end && w_last_data) begin
          w_next = w_par_next ? ST_PARITY : ST_STOP;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) w_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_bit_end && (!r_stop2 || r_stop_cnt)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Frame datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift    <= '0;
      r_nbits    <= '0;
      r_stop2    <= 1'b0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
    end else begin
      if (w_start) begin
        r_shift    <= bus.i_tx_data;
        r_nbits    <= w_nbits;
        r_stop2    <= bus.i_stop2;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
      end
      if ((r_state == ST_DATA) && w_bit_end) begin
        r_shift   <= r_shift >> 1;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if ((r_state == ST_STOP) && w_bit_end) begin
        r_stop_cnt <= 1'b1;
      end
    end
  end

  // Line level for the current state; registering it places the line one
  // cycle behind the state, which is what delays the start bit by one cycle
  // after the FIFO pop strobe.
  always_comb begin
    w_line = 1'b1;
    case (r_state)
      ST_START:  w_line = 1'b0;
      ST_DATA:   w_line = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_line = r_par_bit;
`endif
      default:   w_line = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fifo_rd   <= 1'b0;
      r_tx_serial <= 1'b1;
      r_busy      <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_fifo_rd   <= w_start;
      r_tx_serial <= w_line;
      r_busy      <= (r_state != ST_IDLE);
      r_tx_done   <= (r_state == ST_STOP) && (w_next == ST_IDLE);
    end
  end

  assign bus.o_fifo_rd   = r_fifo_rd;
  assign bus.o_tx_serial = r_tx_serial;
  assign bus.o_busy      = r_busy;
  assign bus.o_tx_done   = r_tx_done;

endmodule
`default_nettype wire

// File: doc/transmitter_cfg.md
# transmitter_cfg

Parametrised UART transmitter, the next generation of the fixed 8N1 `Transmitter`. It serialises one word per frame from the TX FIFO, paced by the `baud_generator` oversampling tick. Frame format is selectable at runtime: data length, parity mode and stop-bit count. It sits between the TX FIFO and the UART pin in the UART IP top level.

## Interface
- `SIZE_DATA`, 8: maximum data width and FIFO word width; must be ≥ 5.
- `OVER_SAMPLE`, 16: `i_stick` ticks per bit period; must be ≥ 2.
- `i_clk`  in  1: system clock.
- `i_rst`  in  1: synchronous reset, active-high.
- `i_stick`  in  1: single-cycle oversample tick from `baud_generator`.
- `i_tx_en`  in  1: transmit enable.
- `i_fifo_empty`  in  1: TX FIFO empty flag.
- `i_tx_data`  in  SIZE_DATA: FIFO head word, valid while `!i_fifo_empty`.
- `i_data_bits`  in  $clog2(SIZE_DATA+1): data bits per frame, range 5..SIZE_DATA.
- `i_parity`  in  2: 00 none, 01 even, 10 odd, 11 treated as none.
- `i_stop2`  in  1: 0 selects one stop bit, 1 selects two.
- `o_fifo_rd`  out  1: one-cycle FIFO pop strobe.
- `o_tx_serial`  out  1: serial line, idle high.
- `o_busy`  out  1: frame in progress.
- `o_tx_done`  out  1: one-cycle pulse at the end of each frame.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START: when `i_tx_en && !i_fifo_empty`.
  - In that cycle, pulse `o_fifo_rd`.
  - In that cycle, latch `i_tx_data`, `i_data_bits`, `i_parity` and `i_stop2` into shadow registers.
  - Config changes during a frame have no effect until the next frame.
- Each bit lasts `OVER_SAMPLE` `i_stick` ticks, counted by a tick counter reset on each state entry.
- START drives 0, then goes to DATA.
- DATA shifts out LSB first, for the latched `data_bits` count.
  - Out-of-range counts are clamped: values < 5 act as 5; values > SIZE_DATA act as SIZE_DATA.
  - Afterwards go to PARITY if parity is enabled, else STOP.
- PARITY drives the XOR of the transmitted data bits for even parity, or its inverse for odd parity.
- STOP drives 1 for 1 or 2 bit periods, then returns to IDLE, pulsing `o_tx_done` in the cycle of that transition.
- `i_tx_en` deasserted mid-frame: the frame completes; no new frame starts.
- `i_fifo_empty` asserted mid-frame: no effect.
- `i_rst` asserted mid-frame: the frame is aborted and the line returns high in the next cycle. No done pulse is produced.

## Timing
- Reset values: `o_tx_serial`=1, `o_fifo_rd`=0, `o_busy`=0, `o_tx_done`=0; FSM is in IDLE; counters are 0.
- All outputs are registered.
- `o_tx_serial` falls in the cycle after the `o_fifo_rd` pulse.
- Bit-boundary alignment:
  - The line changes in the cycle after the `i_stick` that completes the tick count.
  - Frame start is not aligned to `i_stick`: the start bit may be up to one stick period shorter than the other bits.
- `o_busy` is high from the cycle after `o_fifo_rd` through the cycle of `o_tx_done`.
- Back-to-back frames: the FSM spends at least one cycle in IDLE between frames, with the line high.
- Frame length in bits: 1 + data_bits + (parity ? 1 : 0) + (stop2 ? 2 : 1).

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state and `i_parity` are functional.
- Undefined:
  - The PARITY state and parity logic are not built.
  - `i_parity` remains a port but is ignored.
  - Frames never carry a parity bit.

## Structure
- Package `uart_pkg`:
  - state enum `tx_state_e`;
  - parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - constant `MIN_DATA_BITS` = 5.
- Sub-module `tx_bit_timer`: tick counter that raises a bit-end strobe after `OVER_SAMPLE` sticks, restartable by the FSM.

## Test plan
The bench drives `i_stick` every 4 clocks with `OVER_SAMPLE`=16, giving 64 clocks per bit.
- 8N1, data 0x55:
  - exactly one `o_fifo_rd` pulse;
  - line sequence 0,1,0,1,0,1,0,1,0,1 (640 clocks);
  - `o_tx_done` pulses once.
- 8E1, data 0x55 → parity bit 0. 8O1, data 0x55 → parity bit 1. Total 704 clocks each.
- 7N2, data 0xFF:
  - data bits 1×7;
  - stop high for 128 clocks;
  - bit 7 of the word is not sent.
- FIFO holds 3 words with `i_tx_en` high → three frames, each separated by ≥1 idle-high cycle; `o_fifo_rd` pulses 3 times; `o_tx_done` pulses 3 times.
- `i_rst` asserted mid-DATA:
  - next cycle `o_tx_serial`=1 and `o_busy`=0;
  - no `o_tx_done` pulse;
  - the next frame after reset is transmitted correctly.
- Without `UART_TX_PARITY_EN`, `i_parity`=01, data 0x55 → 8N1 frame of 640 clocks.
